// File: rtl/bram_port_arbiter_if.sv
// Bundle of the lookup, config and BRAM-port signals around the arbiter.
// The slave modport is the arbiter's view; master is the surroundings
// (requesters plus the BRAM itself).
interface bram_port_arbiter_if #(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
);
  logic                  lk_req_valid;
  logic                  lk_req_ready;
  logic [ADDR_WIDTH-1:0] lk_req_addr;
  logic                  lk_rsp_valid;
  logic [DATA_WIDTH-1:0] lk_rsp_data;

  logic                  cf_req_valid;
  logic                  cf_req_ready;
  logic [NUM_COL-1:0]    cf_req_we;
  logic [ADDR_WIDTH-1:0] cf_req_addr;
  logic [DATA_WIDTH-1:0] cf_req_din;
  logic                  cf_rsp_valid;
  logic [DATA_WIDTH-1:0] cf_rsp_data;

  logic                  bram_ena;
  logic [NUM_COL-1:0]    bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_din;
  logic [DATA_WIDTH-1:0] bram_dout;

  modport slave (
    input  lk_req_valid, lk_req_addr,
    output lk_req_ready, lk_rsp_valid, lk_rsp_data,
    input  cf_req_valid, cf_req_we, cf_req_addr, cf_req_din,
    output cf_req_ready, cf_rsp_valid, cf_rsp_data,
    output bram_ena, bram_we, bram_addr, bram_din,
    input  bram_dout
  );

  modport master (
    output lk_req_valid, lk_req_addr,
    input  lk_req_ready, lk_rsp_valid, lk_rsp_data,
    output cf_req_valid, cf_req_we, cf_req_addr, cf_req_din,
    input  cf_req_ready, cf_rsp_valid, cf_rsp_data,
    input  bram_ena, bram_we, bram_addr, bram_din,
    output bram_dout
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between the lookup path (read-only, normally favoured)
// and the config path (byte-masked read/write). Config is promoted after
// MAX_WAIT consecutive lost cycles. Responses return one cycle after the
// grant, tagged to whichever side won.
module bram_port_arbiter #(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
  parameter int MAX_WAIT   = 8
) (
  input logic               clk,
  input logic               rst,
  bram_port_arbiter_if.slave bus
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              lk_rsp_q, lk_rsp_d;
  logic              cf_rsp_q, cf_rsp_d;
  logic              promote;
  logic              lk_grant;
  logic              cf_grant;

  // Grant decision; nothing is granted while reset is held.
  always_comb begin
    promote  = (wait_cnt_q >= WAIT_MAX);
    lk_grant = 1'b0;
    cf_grant = 1'b0;
    if (!rst) begin
      if (bus.cf_req_valid && (promote || !bus.lk_req_valid)) begin
        cf_grant = 1'b1;
      end else if (bus.lk_req_valid) begin
        lk_grant = 1'b1;
      end
    end
  end

  // Handshake and BRAM port drive from the winner; zeros when idle.
  always_comb begin
    bus.lk_req_ready = lk_grant;
    bus.cf_req_ready = cf_grant;
    bus.bram_ena     = lk_grant | cf_grant;
    bus.bram_we      = '0;
    bus.bram_addr    = '0;
    bus.bram_din     = '0;
    if (cf_grant) begin
      bus.bram_we   = bus.cf_req_we;
      bus.bram_addr = bus.cf_req_addr;
      bus.bram_din  = bus.cf_req_din;
    end else if (lk_grant) begin
      bus.bram_addr = bus.lk_req_addr;
    end
  end

  // Next response tags and starvation counter.
  always_comb begin
    lk_rsp_d   = lk_grant;
    cf_rsp_d   = cf_grant && (bus.cf_req_we == '0);
    wait_cnt_d = wait_cnt_q;
    if (!bus.cf_req_valid || cf_grant) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      lk_rsp_q   <= 1'b0;
      cf_rsp_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      lk_rsp_q   <= lk_rsp_d;
      cf_rsp_q   <= cf_rsp_d;
    end
  end

  // Responses are masked during reset so a read granted just before reset
  // rises never surfaces. Read data passes straight through from the BRAM.
  always_comb begin
    bus.lk_rsp_valid = lk_rsp_q && !rst;
    bus.cf_rsp_valid = cf_rsp_q && !rst;
    bus.lk_rsp_data  = bus.bram_dout;
    bus.cf_rsp_data  = bus.bram_dout;
  end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: a table of single-cycle vectors,
// hand-written multi-cycle sequences, then randomized traffic checked against
// a cycle-level reference model with its own memory image.
module tb_bram_port_arbiter;
  localparam int MAX_WAIT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_port_arbiter_if bus ();

  bram_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'h1122_3344;
    return {8'(i), 8'(~i), 8'(i * 3), 8'hC3};
  endfunction

  // Behavioural BRAM: registered read, no_change on write.
  logic [31:0] mem [1024];
  bit          mem_init_done;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end else if (bus.bram_ena) begin
      if (bus.bram_we == 4'b0) begin
        bus.bram_dout <= mem[bus.bram_addr];
      end else begin
        for (int c = 0; c < 4; c++)
          if (bus.bram_we[c]) mem[bus.bram_addr][c*8 +: 8] <= bus.bram_din[c*8 +: 8];
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [1024];
  int          ref_wait;
  bit          pend_lk, pend_cf;
  logic [31:0] pend_data;
  int          obs_lost;

  // Last observed DUT outputs.
  bit          obs_lk_rdy, obs_cf_rdy, obs_ena, obs_lk_rsp, obs_cf_rsp;
  logic [3:0]  obs_we;
  logic [9:0]  obs_addr;
  logic [31:0] obs_lk_data, obs_cf_data;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive, check against the model at negedge, advance.
  task automatic cycle(input bit r, input bit lv, input logic [9:0] la,
                       input bit cv, input logic [3:0] we, input logic [9:0] ca,
                       input logic [31:0] din);
    bit          cf_g, lk_g, e_lk_rsp, e_cf_rsp;
    logic [9:0]  e_addr;
    logic [31:0] e_din;
    logic [3:0]  e_we;
    rst              = r;
    bus.lk_req_valid = lv;
    bus.lk_req_addr  = la;
    bus.cf_req_valid = cv;
    bus.cf_req_we    = we;
    bus.cf_req_addr  = ca;
    bus.cf_req_din   = din;
    @(negedge clk);
    cf_g = !r && cv && (ref_wait >= MAX_WAIT || !lv);
    lk_g = !r && !cf_g && lv;
    e_we   = cf_g ? we : 4'b0;
    e_addr = cf_g ? ca : (lk_g ? la : 10'd0);
    e_din  = cf_g ? din : 32'd0;
    e_lk_rsp = !r && pend_lk;
    e_cf_rsp = !r && pend_cf;

    obs_lk_rdy  = bus.lk_req_ready;
    obs_cf_rdy  = bus.cf_req_ready;
    obs_ena     = bus.bram_ena;
    obs_we      = bus.bram_we;
    obs_addr    = bus.bram_addr;
    obs_lk_rsp  = bus.lk_rsp_valid;
    obs_cf_rsp  = bus.cf_rsp_valid;
    obs_lk_data = bus.lk_rsp_data;
    obs_cf_data = bus.cf_rsp_data;

    chk("grant", {obs_lk_rdy, obs_cf_rdy, obs_ena}, {lk_g, cf_g, lk_g | cf_g});
    chk("bram_port", {bus.bram_we, bus.bram_addr, bus.bram_din}, {e_we, e_addr, e_din});
    chk("rsp_valid", {obs_lk_rsp, obs_cf_rsp}, {e_lk_rsp, e_cf_rsp});
    if (e_lk_rsp && obs_lk_rsp) chk("lk_rsp_data", obs_lk_data, pend_data);
    if (e_cf_rsp && obs_cf_rsp) chk("cf_rsp_data", obs_cf_data, pend_data);

    if (r) obs_lost = 0;
    else if (cv && !obs_cf_rdy) obs_lost++;
    else obs_lost = 0;
    if (!r && cv) chk("cf_starve_bound", obs_lost <= MAX_WAIT, 1);

    pend_lk   = lk_g;
    pend_cf   = cf_g && (we == 4'b0);
    pend_data = ref_mem[e_addr];
    if (cf_g && we != 4'b0)
      for (int c = 0; c < 4; c++)
        if (we[c]) ref_mem[ca][c*8 +: 8] = din[c*8 +: 8];
    if (r || !cv || cf_g) ref_wait = 0;
    else ref_wait = (ref_wait + 1 > MAX_WAIT) ? MAX_WAIT : ref_wait + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 10'd0, 1'b0, 4'b0, 10'd0, 32'd0);
  endtask

  typedef struct {
    bit          lk_v;
    logic [9:0]  lk_addr;
    bit          cf_v;
    logic [3:0]  we;
    logic [9:0]  cf_addr;
    logic [31:0] din;
    bit          e_lk_rdy;
    bit          e_cf_rdy;
    bit          e_ena;
    logic [3:0]  e_we;
    logic [9:0]  e_addr;
  } vec_t;

  vec_t tbl [8];
  bit   cf_seen [27];
  int   rsp_cnt;

  initial begin
    tbl[0] = '{0, 10'h000, 0, 4'h0, 10'h000, 32'h0,          0, 0, 0, 4'h0, 10'h000};
    tbl[1] = '{1, 10'h003, 0, 4'h0, 10'h000, 32'h0,          1, 0, 1, 4'h0, 10'h003};
    tbl[2] = '{0, 10'h000, 1, 4'h0, 10'h004, 32'h0,          0, 1, 1, 4'h0, 10'h004};
    tbl[3] = '{0, 10'h000, 1, 4'hF, 10'h030, 32'h0102_0304,  0, 1, 1, 4'hF, 10'h030};
    tbl[4] = '{1, 10'h001, 1, 4'h3, 10'h031, 32'h5555_5555,  1, 0, 1, 4'h0, 10'h001};
    tbl[5] = '{1, 10'h002, 0, 4'h0, 10'h000, 32'h0,          1, 0, 1, 4'h0, 10'h002};
    tbl[6] = '{1, 10'h006, 1, 4'h0, 10'h007, 32'h0,          1, 0, 1, 4'h0, 10'h006};
    tbl[7] = '{0, 10'h000, 1, 4'h0, 10'h007, 32'h0,          0, 1, 1, 4'h0, 10'h007};

    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    ref_wait = 0; pend_lk = 0; pend_cf = 0; pend_data = '0; obs_lost = 0;
    bus.lk_req_valid = 0; bus.lk_req_addr = '0;
    bus.cf_req_valid = 0; bus.cf_req_we = '0; bus.cf_req_addr = '0; bus.cf_req_din = '0;
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b1, 10'h1, 1'b1, 4'h0, 10'h2, 32'h0);
    cycle(1'b1, 1'b0, 10'h0, 1'b0, 4'h0, 10'h0, 32'h0);

    // Table-driven single-cycle vectors from a fresh reset.
    foreach (tbl[i]) begin
      cycle(1'b0, tbl[i].lk_v, tbl[i].lk_addr, tbl[i].cf_v, tbl[i].we, tbl[i].cf_addr, tbl[i].din);
      chk($sformatf("tbl%0d", i), {obs_lk_rdy, obs_cf_rdy, obs_ena, obs_we, obs_addr},
          {tbl[i].e_lk_rdy, tbl[i].e_cf_rdy, tbl[i].e_ena, tbl[i].e_we, tbl[i].e_addr});
    end
    idle();

    // Lookup alone for three cycles: three grants, three responses.
    rsp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 10'h005, 1'b0, 4'h0, 10'h0, 32'h0);
      if (obs_lk_rsp) rsp_cnt++;
    end
    idle();
    if (obs_lk_rsp) rsp_cnt++;
    chk("lk_only_rsp_count", rsp_cnt, 3);
    chk("lk_only_last_data", obs_lk_data, init_word(5));

    // Byte-masked write over 0x11223344, then read it back.
    cycle(1'b0, 1'b0, 10'h0, 1'b1, 4'b0101, 10'h010, 32'hAABB_CCDD);
    cycle(1'b0, 1'b0, 10'h0, 1'b1, 4'b0000, 10'h010, 32'h0);
    chk("cf_wr_no_rsp", obs_cf_rsp, 1'b0);
    idle();
    chk("cf_rd_valid", obs_cf_rsp, 1'b1);
    chk("cf_masked_data", obs_cf_data, 32'h11BB_33DD);

    // Both requesters continuously valid: cf wins every ninth cycle.
    for (int i = 0; i < 27; i++) begin
      cycle(1'b0, 1'b1, 10'(i), 1'b1, 4'h0, 10'h100 + 10'(i), 32'h0);
      cf_seen[i] = obs_cf_rdy;
    end
    for (int i = 0; i < 27; i++) chk($sformatf("promote_c%0d", i), cf_seen[i], (i % 9) == 8);
    idle();

    // Config alone is granted at once; a lookup of the written word sees new data.
    cycle(1'b0, 1'b0, 10'h0, 1'b1, 4'hF, 10'h020, 32'hCAFE_F00D);
    chk("cf_alone_grant", obs_cf_rdy, 1'b1);
    chk("cf_alone_wait", dut.wait_cnt_q, 0);
    cycle(1'b0, 1'b1, 10'h020, 1'b0, 4'h0, 10'h0, 32'h0);
    idle();
    chk("wr_then_lk_valid", obs_lk_rsp, 1'b1);
    chk("wr_then_lk_data", obs_lk_data, 32'hCAFE_F00D);

    // Reset right after a lookup grant swallows the response.
    cycle(1'b0, 1'b1, 10'h005, 1'b0, 4'h0, 10'h0, 32'h0);
    cycle(1'b1, 1'b1, 10'h005, 1'b1, 4'hF, 10'h005, 32'hFFFF_FFFF);
    chk("rst_outputs", {obs_lk_rdy, obs_cf_rdy, obs_ena, obs_we, obs_lk_rsp, obs_cf_rsp}, 9'd0);
    idle();
    chk("rst_no_late_rsp", obs_lk_rsp, 1'b0);
    cycle(1'b0, 1'b1, 10'h005, 1'b0, 4'h0, 10'h0, 32'h0);
    chk("first_grant_after_rst", obs_lk_rdy, 1'b1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      bit         r, lv, cv;
      logic [3:0] we;
      r  = ($urandom_range(0, 99) == 0);
      lv = ($urandom_range(0, 99) < 70);
      cv = ($urandom_range(0, 99) < 50);
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      cycle(r, lv, 10'($urandom_range(0, 15)), cv, we, 10'($urandom_range(0, 15)), $urandom);
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
